// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and width defaults for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    OWN_CORE = 1'b0,
    OWN_DBG  = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port (core / loader) arbiter for a single unified memory,
//               one transaction in flight, core priority with loader anti-starvation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  output logic [DATA_W-1:0] c_rdata,
  output logic              core_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  arb_state_t          state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                c_done_q, c_done_d;
  logic                d_done_q, d_done_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic idle_ok;
  logic d_win;
  logic c_win;

  // Grants are decided combinationally in IDLE so the access starts on the very next cycle.
  assign idle_ok = (state_q == IDLE) && !reset;
  assign d_win   = idle_ok && d_req && ((starve_q == STARVE_TOP) || !c_req);
  assign c_win   = idle_ok && c_req && !d_win;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    c_done_d  = 1'b0;
    d_done_d  = 1'b0;
    mem_we_d  = 1'b0;
    c_rdata_d = c_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (c_win || d_win) begin
          owner_d  = d_win ? OWN_DBG : OWN_CORE;
          we_d     = d_win ? d_we    : c_we;
          addr_d   = d_win ? d_addr  : c_addr;
          wdata_d  = d_win ? d_wdata : c_wdata;
          mem_we_d = d_win ? d_we    : c_we;
          cnt_d    = CNT_INIT;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (owner_q == OWN_DBG) begin
            d_done_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end else begin
            c_done_d = 1'b1;
            if (!we_q) c_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A waiting loader ages in both states; in IDLE d_win is only true when it is granted.
    if (d_win) begin
      starve_d = '0;
    end else if (d_req && (starve_q != STARVE_TOP)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_CORE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      c_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      c_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      c_done_q  <= c_done_d;
      d_done_q  <= d_done_d;
      mem_we_q  <= mem_we_d;
      c_rdata_q <= c_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign c_gnt      = c_win;
  assign d_gnt      = d_win;
  assign c_done     = c_done_q;
  assign d_done     = d_done_q;
  assign c_rdata    = c_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign core_stall = c_req && !c_done_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = (state_q == ACCESS);

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench; instance 0 uses MEM_LAT=1, instance 1 MEM_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk;
  logic        rst        [2];
  logic        c_req      [2];
  logic        c_we       [2];
  logic [31:0] c_addr     [2];
  logic [31:0] c_wdata    [2];
  logic        c_gnt      [2];
  logic        c_done     [2];
  logic [31:0] c_rdata    [2];
  logic        core_stall [2];
  logic        d_req      [2];
  logic        d_we       [2];
  logic [31:0] d_addr     [2];
  logic [31:0] d_wdata    [2];
  logic        d_gnt      [2];
  logic        d_done     [2];
  logic [31:0] d_rdata    [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_wdata  [2];
  logic        mem_we     [2];
  logic [31:0] mem_rdata  [2];
  logic        busy       [2];

  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT((i == 0) ? 1 : 3), .STARVE_MAX(4)
    ) u_dut (
      .clk(clk), .reset(rst[i]),
      .c_req(c_req[i]), .c_we(c_we[i]), .c_addr(c_addr[i]), .c_wdata(c_wdata[i]),
      .c_gnt(c_gnt[i]), .c_done(c_done[i]), .c_rdata(c_rdata[i]), .core_stall(core_stall[i]),
      .d_req(d_req[i]), .d_we(d_we[i]), .d_addr(d_addr[i]), .d_wdata(d_wdata[i]),
      .d_gnt(d_gnt[i]), .d_done(d_done[i]), .d_rdata(d_rdata[i]),
      .mem_addr(mem_addr[i]), .mem_wdata(mem_wdata[i]), .mem_we(mem_we[i]),
      .mem_rdata(mem_rdata[i]), .busy(busy[i])
    );
    assign mem_rdata[i] = mem[mem_addr[i][7:0]];
  end

  // Shared asynchronous-read word memory, loaded while instance 0 is in reset.
  always @(posedge clk) begin
    if (rst[0]) begin
      for (int k = 0; k < 256; k++) mem[k] <= (k == 16) ? 32'hDEADBEEF : 32'h0;
    end else begin
      if (mem_we[0]) mem[mem_addr[0][7:0]] <= mem_wdata[0];
      if (mem_we[1]) mem[mem_addr[1][7:0]] <= mem_wdata[1];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      assert (!(c_gnt[i] && d_gnt[i]) && !(c_done[i] && d_done[i]) && !(mem_we[i] && !busy[i]))
      else begin
        n_err++;
        $error("FAIL monitor%0d gnt=%b%b done=%b%b we=%b busy=%b required no overlap",
               i, c_gnt[i], d_gnt[i], c_done[i], d_done[i], mem_we[i], busy[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      c_req[i] = 1'b0; c_we[i] = 1'b0; c_addr[i] = '0; c_wdata[i] = '0;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    nxt(); nxt();
    smp();
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt",   {30'd0, c_gnt[i], d_gnt[i]}, 32'd0);
      chk("rst_done",  {30'd0, c_done[i], d_done[i]}, 32'd0);
      chk("rst_we",    {30'd0, mem_we[i], busy[i]}, 32'd0);
      chk("rst_addr",  mem_addr[i], 32'd0);
      chk("rst_wdata", mem_wdata[i], 32'd0);
      chk("rst_crd",   c_rdata[i], 32'd0);
      chk("rst_drd",   d_rdata[i], 32'd0);
    end
    nxt();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Core read of 0x10, MEM_LAT=1.
    nxt();
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 32'h10;
    smp();
    chk("t1_gnt", {31'd0, c_gnt[0]}, 32'd1);
    chk("t1_stall", {31'd0, core_stall[0]}, 32'd1);
    chk("t1_busy0", {31'd0, busy[0]}, 32'd0);
    nxt();
    c_req[0] = 1'b0;
    smp();
    chk("t1_gnt_off", {31'd0, c_gnt[0]}, 32'd0);
    chk("t1_busy1", {31'd0, busy[0]}, 32'd1);
    chk("t1_maddr", mem_addr[0], 32'h10);
    chk("t1_mwe", {31'd0, mem_we[0]}, 32'd0);
    chk("t1_nodone", {31'd0, c_done[0]}, 32'd0);
    nxt();
    smp();
    chk("t1_done", {31'd0, c_done[0]}, 32'd1);
    chk("t1_rdata", c_rdata[0], 32'hDEADBEEF);
    chk("t1_busy2", {31'd0, busy[0]}, 32'd0);
    nxt();
    smp();
    chk("t1_done_off", {31'd0, c_done[0]}, 32'd0);

    // Loader write 0x1234 to 0x40, then core reads it back.
    nxt();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h1234;
    smp();
    chk("t2_dgnt", {31'd0, d_gnt[0]}, 32'd1);
    chk("t2_cgnt", {31'd0, c_gnt[0]}, 32'd0);
    nxt();
    d_req[0] = 1'b0;
    smp();
    chk("t2_mwe", {31'd0, mem_we[0]}, 32'd1);
    chk("t2_maddr", mem_addr[0], 32'h40);
    chk("t2_mwdata", mem_wdata[0], 32'h1234);
    nxt();
    smp();
    chk("t2_mwe_off", {31'd0, mem_we[0]}, 32'd0);
    chk("t2_ddone", {31'd0, d_done[0]}, 32'd1);
    chk("t2_drd_hold", d_rdata[0], 32'd0);
    nxt();
    c_req[0] = 1'b1; c_addr[0] = 32'h40;
    smp();
    chk("t2_cgnt_rd", {31'd0, c_gnt[0]}, 32'd1);
    nxt();
    c_req[0] = 1'b0;
    nxt();
    smp();
    chk("t2_cdone", {31'd0, c_done[0]}, 32'd1);
    chk("t2_crdata", c_rdata[0], 32'h1234);
    chk("t2_drd_keep", d_rdata[0], 32'd0);

    // Both requesting continuously: core, core, then loader forced.
    nxt();
    c_req[0] = 1'b1; c_addr[0] = 32'h10;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      smp();
      chk($sformatf("t3_cgnt%0d", k), {31'd0, c_gnt[0]}, {31'd0, (k == 0 || k == 2)});
      chk($sformatf("t3_dgnt%0d", k), {31'd0, d_gnt[0]}, {31'd0, (k == 4)});
      chk($sformatf("t3_cdone%0d", k), {31'd0, c_done[0]}, {31'd0, (k == 2 || k == 4)});
    end
    chk("t3_crdata", c_rdata[0], 32'hDEADBEEF);
    nxt();
    d_req[0] = 1'b0;
    smp();
    chk("t3_busy", {31'd0, busy[0]}, 32'd1);
    chk("t3_cgnt_wait", {31'd0, c_gnt[0]}, 32'd0);
    nxt();
    smp();
    chk("t3_ddone", {31'd0, d_done[0]}, 32'd1);
    chk("t3_drdata", d_rdata[0], 32'h1234);
    chk("t3_cgnt_after", {31'd0, c_gnt[0]}, 32'd1);
    nxt();
    c_req[0] = 1'b0;
    nxt();
    smp();
    chk("t3_cdone_last", {31'd0, c_done[0]}, 32'd1);

    // Instance 1, MEM_LAT=3: back-to-back core reads.
    nxt();
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 32'h10;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) nxt();
      smp();
      chk($sformatf("t4_gnt%0d", k), {31'd0, c_gnt[1]}, {31'd0, (k % 4 == 0)});
      chk($sformatf("t4_done%0d", k), {31'd0, c_done[1]}, {31'd0, (k > 0 && k % 4 == 0)});
      chk($sformatf("t4_stall%0d", k), {31'd0, core_stall[1]}, {31'd0, !(k > 0 && k % 4 == 0)});
      chk($sformatf("t4_busy%0d", k), {31'd0, busy[1]}, {31'd0, (k % 4 != 0)});
    end
    chk("t4_rdata", c_rdata[1], 32'hDEADBEEF);

    // Reset during second ACCESS cycle of the third read.
    nxt();
    c_req[1] = 1'b0;
    nxt();
    rst[1] = 1'b1;
    smp();
    chk("t5_busy_pre", {31'd0, busy[1]}, 32'd1);
    nxt();
    smp();
    chk("t5_busy", {31'd0, busy[1]}, 32'd0);
    chk("t5_done", {31'd0, c_done[1]}, 32'd0);
    chk("t5_rdata", c_rdata[1], 32'd0);
    chk("t5_maddr", mem_addr[1], 32'd0);
    chk("t5_gnt", {31'd0, c_gnt[1]}, 32'd0);
    nxt();
    rst[1] = 1'b0;
    smp();
    chk("t5_nodone", {31'd0, c_done[1]}, 32'd0);
    nxt();
    c_req[1] = 1'b1; c_addr[1] = 32'h40;
    smp();
    chk("t5_regnt", {31'd0, c_gnt[1]}, 32'd1);
    nxt();
    c_req[1] = 1'b0;
    nxt(); nxt(); nxt();
    smp();
    chk("t5_redone", {31'd0, c_done[1]}, 32'd1);
    chk("t5_rerdata", c_rdata[1], 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
